// File: rtl/dma_burst_scheduler_pkg.sv
// Shared configuration and types for the cluster DMA burst scheduler.
// Parameter defaults mirror the cluster DMA configuration.
package dma_burst_scheduler_pkg;

  localparam int unsigned N_DMAS             = 4;
  localparam int unsigned DMA_MAX_BURST_SIZE = 2048;
  localparam int unsigned DMA_MAX_N_TXNS     = 64;
  localparam int unsigned DMA_BOUNDARY       = 4096;
  localparam int unsigned DMA_ADDR_W         = 32;
  localparam int unsigned DMA_LEN_W          = 32;

  typedef struct packed {
    logic [DMA_ADDR_W-1:0] src;
    logic [DMA_ADDR_W-1:0] dst;
    logic [DMA_LEN_W-1:0]  len;
  } dma_desc_t;

  typedef enum logic {
    SCHED_IDLE  = 1'b0,
    SCHED_SPLIT = 1'b1
  } sched_state_e;

endpackage

// File: rtl/dma_chunk_calc.sv
// Size of the next burst: min of remaining bytes, max burst size and the
// room left before the next boundary on source and destination.
module dma_chunk_calc
  import dma_burst_scheduler_pkg::*;
#(
  parameter int unsigned LEN_W       = DMA_LEN_W,
  parameter int unsigned MAX_BURST_B = DMA_MAX_BURST_SIZE,
  parameter int unsigned BOUNDARY_B  = DMA_BOUNDARY
) (
  input  logic [$clog2(BOUNDARY_B)-1:0] src_off,
  input  logic [$clog2(BOUNDARY_B)-1:0] dst_off,
  input  logic [LEN_W-1:0]              remaining,
  output logic [$clog2(MAX_BURST_B):0]  chunk
);

  localparam int unsigned OFF_W = $clog2(BOUNDARY_B);
  localparam int unsigned RW    = OFF_W + 1;
  localparam int unsigned CW    = $clog2(MAX_BURST_B) + 1;

  logic [RW-1:0] src_room;
  logic [RW-1:0] dst_room;
  logic [RW-1:0] cap;

  always_comb begin
    src_room = RW'(BOUNDARY_B) - {1'b0, src_off};
    dst_room = RW'(BOUNDARY_B) - {1'b0, dst_off};
    cap      = RW'(MAX_BURST_B);
    if (src_room < cap) cap = src_room;
    if (dst_room < cap) cap = dst_room;
    if (remaining < LEN_W'(cap)) chunk = CW'(remaining);
    else                         chunk = CW'(cap);
  end

endmodule

// File: rtl/dma_burst_scheduler.sv
// Shares one DMA backend between N_REQ frontends: round-robin descriptor
// accept, boundary-safe burst splitting, in-flight cap and per-requester done.
//
// state       | meaning
// SCHED_IDLE  | waiting for a descriptor from a requester with no pending transfer
// SCHED_SPLIT | issuing bursts of the captured descriptor to the backend
module dma_burst_scheduler
  import dma_burst_scheduler_pkg::*;
#(
  parameter int unsigned N_REQ       = N_DMAS,
  parameter int unsigned ADDR_W      = DMA_ADDR_W,
  parameter int unsigned LEN_W       = DMA_LEN_W,
  parameter int unsigned MAX_BURST_B = DMA_MAX_BURST_SIZE,
  parameter int unsigned BOUNDARY_B  = DMA_BOUNDARY,
  parameter int unsigned MAX_TXNS    = DMA_MAX_N_TXNS
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [N_REQ-1:0]                  req_valid_i,
  output logic [N_REQ-1:0]                  req_ready_o,
  input  logic [N_REQ-1:0][ADDR_W-1:0]      req_src_i,
  input  logic [N_REQ-1:0][ADDR_W-1:0]      req_dst_i,
  input  logic [N_REQ-1:0][LEN_W-1:0]       req_len_i,
  output logic                              burst_valid_o,
  input  logic                              burst_ready_i,
  output logic [ADDR_W-1:0]                 burst_src_o,
  output logic [ADDR_W-1:0]                 burst_dst_o,
  output logic [$clog2(MAX_BURST_B):0]      burst_len_o,
  output logic [$clog2(N_REQ)-1:0]          burst_id_o,
  output logic                              burst_last_o,
  input  logic                              cpl_valid_i,
  input  logic [$clog2(N_REQ)-1:0]          cpl_id_i,
  output logic [N_REQ-1:0]                  done_o,
  output logic [$clog2(MAX_TXNS+1)-1:0]     outstanding_o,
  output logic                              busy_o
);

  localparam int unsigned ID_W  = $clog2(N_REQ);
  localparam int unsigned CW    = $clog2(MAX_BURST_B) + 1;
  localparam int unsigned OW    = $clog2(MAX_TXNS + 1);
  localparam int unsigned OFF_W = $clog2(BOUNDARY_B);

  sched_state_e     state_q, state_d;
  logic [ID_W-1:0]  rr_ptr_q, cur_id_q, gnt_id, idx;
  logic             gnt_valid, grant, hs, last, cpl_ok;
  logic [ADDR_W-1:0] src_q, dst_q;
  logic [LEN_W-1:0] rem_q;
  logic [CW-1:0]    chunk;
  logic [OW-1:0]    inflight_q [N_REQ];
  logic [OW-1:0]    inflight_d [N_REQ];
  logic [OW-1:0]    outstanding_q, outstanding_d;
  logic [N_REQ-1:0] all_issued_q, done_q, pending;

  dma_chunk_calc #(
    .LEN_W       (LEN_W),
    .MAX_BURST_B (MAX_BURST_B),
    .BOUNDARY_B  (BOUNDARY_B)
  ) u_chunk (
    .src_off   (src_q[OFF_W-1:0]),
    .dst_off   (dst_q[OFF_W-1:0]),
    .remaining (rem_q),
    .chunk     (chunk)
  );

  // A requester is pending from its first burst issue until its done pulse.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) pending[i] = all_issued_q[i] || (inflight_q[i] != '0);
  end

  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = '0;
    idx       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = rr_ptr_q + ID_W'(k);
      if (!gnt_valid && req_valid_i[idx] && !pending[idx]) begin
        gnt_valid = 1'b1;
        gnt_id    = idx;
      end
    end
  end

  assign last = (LEN_W'(chunk) == rem_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= SCHED_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    req_ready_o   = '0;
    burst_valid_o = 1'b0;
    grant         = 1'b0;
    case (state_q)
      SCHED_IDLE: begin
        if (gnt_valid) begin
          grant               = 1'b1;
          req_ready_o[gnt_id] = 1'b1;
          if (req_len_i[gnt_id] != '0) state_d = SCHED_SPLIT;
        end
      end
      SCHED_SPLIT: begin
        burst_valid_o = (outstanding_q < OW'(MAX_TXNS));
        if (burst_valid_o && burst_ready_i && last) state_d = SCHED_IDLE;
      end
      default: state_d = SCHED_IDLE;
    endcase
  end

  assign hs     = burst_valid_o && burst_ready_i;
  assign cpl_ok = cpl_valid_i && (inflight_q[cpl_id_i] != '0);

  // Issue and completion for the same id in one cycle cancel out.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      inflight_d[i] = inflight_q[i];
      if (hs && cur_id_q == ID_W'(i) && !(cpl_ok && cpl_id_i == ID_W'(i)))
        inflight_d[i] = inflight_q[i] + OW'(1);
      else if (!(hs && cur_id_q == ID_W'(i)) && cpl_ok && cpl_id_i == ID_W'(i))
        inflight_d[i] = inflight_q[i] - OW'(1);
    end
    outstanding_d = outstanding_q;
    if (hs && !cpl_ok)      outstanding_d = outstanding_q + OW'(1);
    else if (!hs && cpl_ok) outstanding_d = outstanding_q - OW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q      <= '0;
      cur_id_q      <= '0;
      src_q         <= '0;
      dst_q         <= '0;
      rem_q         <= '0;
      outstanding_q <= '0;
      all_issued_q  <= '0;
      done_q        <= '0;
      for (int i = 0; i < N_REQ; i++) inflight_q[i] <= '0;
    end else begin
      done_q        <= '0;
      outstanding_q <= outstanding_d;
      if (grant) begin
        src_q    <= req_src_i[gnt_id];
        dst_q    <= req_dst_i[gnt_id];
        rem_q    <= req_len_i[gnt_id];
        cur_id_q <= gnt_id;
        rr_ptr_q <= gnt_id + ID_W'(1);
      end
      if (hs) begin
        src_q <= src_q + ADDR_W'(chunk);
        dst_q <= dst_q + ADDR_W'(chunk);
        rem_q <= rem_q - LEN_W'(chunk);
      end
      for (int i = 0; i < N_REQ; i++) begin
        inflight_q[i] <= inflight_d[i];
        if (hs && last && cur_id_q == ID_W'(i)) begin
          all_issued_q[i] <= 1'b1;
        end else if (all_issued_q[i] && inflight_d[i] == '0) begin
          all_issued_q[i] <= 1'b0;
          done_q[i]       <= 1'b1;
        end
      end
      // Zero-length descriptors finish without touching the backend.
      if (grant && req_len_i[gnt_id] == '0) done_q[gnt_id] <= 1'b1;
    end
  end

  assign burst_src_o   = src_q;
  assign burst_dst_o   = dst_q;
  assign burst_len_o   = chunk;
  assign burst_id_o    = cur_id_q;
  assign burst_last_o  = (state_q == SCHED_SPLIT) && last;
  assign done_o        = done_q;
  assign outstanding_o = outstanding_q;
  assign busy_o        = (state_q != SCHED_IDLE) || (outstanding_q != '0);

  a_cpl_has_inflight: assert property (@(posedge clk_i) disable iff (rst_i)
    cpl_valid_i |-> (inflight_q[cpl_id_i] != '0));

endmodule

// File: tb/tb_dma_burst_scheduler.sv
// Scoreboard bench for dma_burst_scheduler: expected bursts are queued when a
// descriptor is accepted and compared as the backend accepts each burst.
module tb_dma_burst_scheduler;
  import dma_burst_scheduler_pkg::*;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [3:0]       req_valid_i;
  logic [3:0]       req_ready_o;
  logic [3:0][31:0] req_src_i, req_dst_i, req_len_i;
  logic             burst_valid_o, burst_ready_i;
  logic [31:0]      burst_src_o, burst_dst_o;
  logic [11:0]      burst_len_o;
  logic [1:0]       burst_id_o;
  logic             burst_last_o;
  logic             cpl_valid_i;
  logic [1:0]       cpl_id_i;
  logic [3:0]       done_o;
  logic [6:0]       outstanding_o;
  logic             busy_o;

  dma_burst_scheduler dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_src_i(req_src_i), .req_dst_i(req_dst_i), .req_len_i(req_len_i),
    .burst_valid_o(burst_valid_o), .burst_ready_i(burst_ready_i),
    .burst_src_o(burst_src_o), .burst_dst_o(burst_dst_o), .burst_len_o(burst_len_o),
    .burst_id_o(burst_id_o), .burst_last_o(burst_last_o),
    .cpl_valid_i(cpl_valid_i), .cpl_id_i(cpl_id_i),
    .done_o(done_o), .outstanding_o(outstanding_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    int unsigned len;
    int unsigned id;
    bit          last;
  } exp_t;

  exp_t exp_q[$];
  int   cpl_q[$];
  exp_t e;
  int   n_vec = 0;
  int   n_err = 0;
  int   hs_count = 0;
  int   done_cnt[4] = '{0, 0, 0, 0};

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void push_exp(logic [31:0] s, logic [31:0] d, int unsigned l, int unsigned id, bit lst);
    exp_t x;
    x.src = s; x.dst = d; x.len = l; x.id = id; x.last = lst;
    exp_q.push_back(x);
  endfunction

  function automatic dma_desc_t mk(logic [31:0] s, logic [31:0] d, logic [31:0] l);
    dma_desc_t x;
    x.src = s; x.dst = d; x.len = l;
    return x;
  endfunction

  // Reference split: walk the transfer, stopping each burst at the next 4 KiB page of either address.
  function automatic void push_model(int unsigned id, dma_desc_t dsc);
    longint unsigned s = dsc.src, t = dsc.dst, r = dsc.len, c, lim;
    while (r > 0) begin
      c = (r < 2048) ? r : 2048;
      lim = ((s / 4096) + 1) * 4096 - s;
      if (lim < c) c = lim;
      lim = ((t / 4096) + 1) * 4096 - t;
      if (lim < c) c = lim;
      push_exp(s[31:0], t[31:0], int'(c), id, c == r);
      s = (s + c) % 64'h1_0000_0000;
      t = (t + c) % 64'h1_0000_0000;
      r = r - c;
    end
  endfunction

  always @(negedge clk_i) begin
    if (!rst_i && burst_valid_o && burst_ready_i) begin
      hs_count++;
      cpl_q.push_back(int'(burst_id_o));
      if (exp_q.size() == 0) begin
        check_val("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
      end else begin
        e = exp_q.pop_front();
        check_val("burst_src",  64'(burst_src_o),  64'(e.src));
        check_val("burst_dst",  64'(burst_dst_o),  64'(e.dst));
        check_val("burst_len",  64'(burst_len_o),  64'(e.len));
        check_val("burst_id",   64'(burst_id_o),   64'(e.id));
        check_val("burst_last", 64'(burst_last_o), 64'(e.last));
      end
    end
    for (int i = 0; i < 4; i++) if (done_o[i]) done_cnt[i]++;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic submit(input int id, input dma_desc_t dsc, output bit ok);
    ok = 1'b0;
    req_valid_i[id] = 1'b1;
    req_src_i[id] = dsc.src;
    req_dst_i[id] = dsc.dst;
    req_len_i[id] = dsc.len;
    for (int c = 0; c < 300 && !ok; c++) begin
      #1;
      if (req_ready_o[id]) ok = 1'b1;
      @(posedge clk_i);
      #1;
    end
    req_valid_i[id] = 1'b0;
    if (!ok) check_val("grant_timeout", 64'(req_ready_o[id]), 64'd1);
  endtask

  task automatic cpl_one();
    if (cpl_q.size() == 0) begin
      check_val("cpl_avail", 64'(cpl_q.size()), 64'd1);
    end else begin
      cpl_valid_i = 1'b1;
      cpl_id_i = 2'(cpl_q.pop_front());
      tick();
      cpl_valid_i = 1'b0;
    end
  endtask

  task automatic wait_hs(input int target);
    for (int c = 0; c < 200 && hs_count < target; c++) tick();
    if (hs_count < target) check_val("hs_timeout", 64'(hs_count), 64'(target));
  endtask

  task automatic drain();
    bit fin = 1'b0;
    burst_ready_i = 1'b1;
    for (int c = 0; c < 3000 && !fin; c++) begin
      if (exp_q.size() == 0 && cpl_q.size() == 0 && !busy_o) begin
        fin = 1'b1;
      end else begin
        if (cpl_q.size() > 0) begin
          cpl_valid_i = 1'b1;
          cpl_id_i = 2'(cpl_q.pop_front());
        end else begin
          cpl_valid_i = 1'b0;
        end
        tick();
      end
    end
    cpl_valid_i = 1'b0;
    if (!fin) check_val("drain_timeout", 64'(exp_q.size()), 64'd0);
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_req_ready"},   64'(req_ready_o),   64'd0);
    check_val({tag, "_burst_valid"}, 64'(burst_valid_o), 64'd0);
    check_val({tag, "_burst_src"},   64'(burst_src_o),   64'd0);
    check_val({tag, "_burst_dst"},   64'(burst_dst_o),   64'd0);
    check_val({tag, "_burst_len"},   64'(burst_len_o),   64'd0);
    check_val({tag, "_burst_id"},    64'(burst_id_o),    64'd0);
    check_val({tag, "_burst_last"},  64'(burst_last_o),  64'd0);
    check_val({tag, "_done"},        64'(done_o),        64'd0);
    check_val({tag, "_outstanding"}, 64'(outstanding_o), 64'd0);
    check_val({tag, "_busy"},        64'(busy_o),        64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int base, k, g;
    dma_desc_t dsc;

    rst_i = 1'b1; req_valid_i = '0; req_src_i = '0; req_dst_i = '0; req_len_i = '0;
    burst_ready_i = 1'b0; cpl_valid_i = 1'b0; cpl_id_i = '0;
    repeat (3) tick();
    check_all_zero("reset");
    rst_i = 1'b0;
    tick();

    // Plain split with explicit done timing
    burst_ready_i = 1'b1;
    base = hs_count;
    submit(0, mk(32'h1000, 32'h2000, 32'd5000), ok);
    if (ok) begin
      push_exp(32'h1000, 32'h2000, 2048, 0, 1'b0);
      push_exp(32'h1800, 32'h2800, 2048, 0, 1'b0);
      push_exp(32'h2000, 32'h3000, 904,  0, 1'b1);
    end
    wait_hs(base + 3);
    cpl_one();
    cpl_one();
    check_val("plain_no_early_done", 64'(done_o), 64'd0);
    cpl_one();
    check_val("plain_done_pulse", 64'(done_o), 64'h1);
    tick();
    check_val("plain_done_single", 64'(done_o), 64'h0);
    check_val("plain_done_count", 64'(done_cnt[0]), 64'd1);

    // Source crosses a page boundary
    submit(1, mk(32'h0F00, 32'h3000, 32'd1024), ok);
    if (ok) begin
      push_exp(32'h0F00, 32'h3000, 256, 1, 1'b0);
      push_exp(32'h1000, 32'h3100, 768, 1, 1'b1);
    end
    drain();
    check_val("boundary_done_count", 64'(done_cnt[1]), 64'd1);

    // Both addresses misaligned: source split first, then destination
    submit(2, mk(32'h0FF8, 32'h1FF0, 32'd64), ok);
    if (ok) begin
      push_exp(32'h0FF8, 32'h1FF0, 8,  2, 1'b0);
      push_exp(32'h1000, 32'h1FF8, 8,  2, 1'b0);
      push_exp(32'h1008, 32'h2000, 48, 2, 1'b1);
    end
    drain();
    check_val("misaligned_done_count", 64'(done_cnt[2]), 64'd2 - 64'd1);

    // Zero length: done next cycle, no burst
    submit(2, mk(32'h7000, 32'h7000, 32'd0), ok);
    check_val("zero_done_pulse", 64'(done_o), 64'h4);
    check_val("zero_no_burst", 64'(burst_valid_o), 64'd0);
    tick();
    check_val("zero_done_single", 64'(done_o), 64'h0);
    check_val("zero_done_count", 64'(done_cnt[2]), 64'd2);

    // Backpressure: outputs hold while the backend stalls
    burst_ready_i = 1'b0;
    dsc = mk(32'h8000, 32'h9000, 32'd4096);
    submit(3, dsc, ok);
    if (ok) push_model(3, dsc);
    for (int c = 0; c < 5; c++) begin
      check_val($sformatf("stall%0d_valid", c), 64'(burst_valid_o), 64'd1);
      check_val($sformatf("stall%0d_src", c),   64'(burst_src_o),   64'h8000);
      check_val($sformatf("stall%0d_dst", c),   64'(burst_dst_o),   64'h9000);
      check_val($sformatf("stall%0d_len", c),   64'(burst_len_o),   64'd2048);
      check_val($sformatf("stall%0d_id", c),    64'(burst_id_o),    64'd3);
      check_val($sformatf("stall%0d_last", c),  64'(burst_last_o),  64'd0);
      tick();
    end
    drain();
    check_val("stall_done_count", 64'(done_cnt[3]), 64'd1);

    // In-flight cap, recovery, and same-cycle issue plus completion
    base = hs_count;
    dsc = mk(32'h0, 32'h100, 32'd131072);
    submit(0, dsc, ok);
    if (ok) push_model(0, dsc);
    repeat (80) tick();
    check_val("cap_outstanding", 64'(outstanding_o), 64'd64);
    check_val("cap_valid_low", 64'(burst_valid_o), 64'd0);
    check_val("cap_issued", 64'(hs_count - base), 64'd64);
    cpl_one();
    check_val("cap_resume_valid", 64'(burst_valid_o), 64'd1);
    check_val("cap_resume_outstanding", 64'(outstanding_o), 64'd63);
    cpl_valid_i = 1'b1;
    cpl_id_i = 2'(cpl_q.pop_front());
    tick();
    cpl_valid_i = 1'b0;
    check_val("same_cycle_outstanding", 64'(outstanding_o), 64'd63);
    drain();
    check_val("cap_done_count", 64'(done_cnt[0]), 64'd2);

    // Reset in the middle of a transfer
    dsc = mk(32'h10000, 32'h20000, 32'd8192);
    submit(1, dsc, ok);
    if (ok) push_model(1, dsc);
    tick();
    tick();
    check_val("midrst_busy_before", 64'(busy_o), 64'd1);
    rst_i = 1'b1;
    tick();
    check_all_zero("midrst");
    rst_i = 1'b0;
    exp_q.delete();
    cpl_q.delete();
    tick();

    // Round robin from a fresh pointer: all four requesters at once
    for (int i = 0; i < 4; i++) begin
      req_src_i[i] = 32'h40000 + 32'(i) * 32'h1000;
      req_dst_i[i] = 32'h50000 + 32'(i) * 32'h1000;
      req_len_i[i] = 32'd32 + 32'(i) * 32'd16;
      req_valid_i[i] = 1'b1;
    end
    k = 0;
    for (int c = 0; c < 200 && k < 4; c++) begin
      #1;
      if (req_ready_o != '0) begin
        g = 0;
        for (int i = 0; i < 4; i++) if (req_ready_o[i]) g = i;
        check_val($sformatf("rr_grant%0d", k), 64'(g), 64'(k));
        push_model(g, mk(req_src_i[g], req_dst_i[g], req_len_i[g]));
        tick();
        req_valid_i[g] = 1'b0;
        k++;
      end else begin
        tick();
      end
    end
    if (k < 4) check_val("rr_timeout", 64'(k), 64'd4);
    req_valid_i = '0;
    drain();

    // A fresh descriptor after the reset and round robin
    submit(1, mk(32'h5000, 32'h6000, 32'd100), ok);
    if (ok) push_exp(32'h5000, 32'h6000, 100, 1, 1'b1);
    drain();

    check_val("final_done0", 64'(done_cnt[0]), 64'd3);
    check_val("final_done1", 64'(done_cnt[1]), 64'd3);
    check_val("final_done2", 64'(done_cnt[2]), 64'd3);
    check_val("final_done3", 64'(done_cnt[3]), 64'd2);
    check_val("final_idle", 64'(busy_o), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
